// File: rtl/sense_pkg.sv
// sense_pkg: shared types and constants for the sense front-end sequencer
package sense_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_SETTLE,
        ST_SAMPLE,
        ST_CLEAR,
        ST_DONE
    } state_t;

    localparam int DEF_BIAS_CYC  = 8;
    localparam int DEF_PRESCALE  = 4;
    localparam int DEF_NSAMP     = 16;
    localparam int DEF_LATCH_CYC = 2;
    localparam int DEF_THRESH    = 12;
    localparam int SETTLE_W      = 4;

    // Width of the shared down-counter: it must hold the largest phase length minus one
    function automatic int cnt_width(input int bias_cyc, input int prescale,
                                     input int nsamp, input int latch_cyc);
        int m;
        m = bias_cyc;
        if ((2 ** SETTLE_W) * prescale > m) m = (2 ** SETTLE_W) * prescale;
        if (nsamp > m) m = nsamp;
        if (latch_cyc > m) m = latch_cyc;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous analog-side input
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // Shift the raw input through two flops to resolve metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/sense_seq_ctrl.sv
// sense_seq_ctrl: bias/LED/sample/clear measurement sequencer with hit count and threshold detect
module sense_seq_ctrl
    import sense_pkg::*;
#(
    parameter int BIAS_CYC  = DEF_BIAS_CYC,
    parameter int PRESCALE  = DEF_PRESCALE,
    parameter int NSAMP     = DEF_NSAMP,
    parameter int LATCH_CYC = DEF_LATCH_CYC,
    parameter int THRESH    = DEF_THRESH,
    parameter int CW        = $clog2(NSAMP + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cont,
    input  logic                abort,
    input  logic [SETTLE_W-1:0] settle_cfg,
    input  logic                comp_raw,
    output logic                bias_en,
    output logic                led_en,
    output logic                latch_clr,
    output logic                busy,
    output logic                done,
    output logic [CW-1:0]       hit_count,
    output logic                detect
);
    localparam int KW = cnt_width(BIAS_CYC, PRESCALE, NSAMP, LATCH_CYC);
    localparam logic [KW-1:0] BIAS_LOAD  = KW'(BIAS_CYC - 1);
    localparam logic [KW-1:0] NSAMP_LOAD = KW'(NSAMP - 1);
    localparam logic [KW-1:0] LATCH_LOAD = KW'(LATCH_CYC - 1);

    state_t        state;
    logic [KW-1:0] cnt;
    logic [KW-1:0] settle_load;
    logic [CW-1:0] acc;
    logic          comp_sync;
    logic          cnt_zero;

    sync_2ff u_comp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (comp_raw),
        .q     (comp_sync)
    );

    assign cnt_zero    = (cnt == '0);
    assign settle_load = KW'((int'(settle_cfg) + 1) * PRESCALE - 1);

    // Sequencer: state, shared phase counter, hit accumulator and registered Moore outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= '0;
            bias_en   <= 1'b0;
            led_en    <= 1'b0;
            latch_clr <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit_count <= '0;
            detect    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != ST_IDLE) begin
                state     <= ST_IDLE;
                cnt       <= '0;
                bias_en   <= 1'b0;
                led_en    <= 1'b0;
                latch_clr <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state   <= ST_BIAS;
                            cnt     <= BIAS_LOAD;
                            bias_en <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    ST_BIAS: begin
                        if (cnt_zero) begin
                            state  <= ST_SETTLE;
                            cnt    <= settle_load;
                            led_en <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_zero) begin
                            state <= ST_SAMPLE;
                            cnt   <= NSAMP_LOAD;
                            acc   <= '0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        acc <= acc + CW'(comp_sync);
                        if (cnt_zero) begin
                            state     <= ST_CLEAR;
                            cnt       <= LATCH_LOAD;
                            led_en    <= 1'b0;
                            latch_clr <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_CLEAR: begin
                        if (cnt_zero) begin
                            state     <= ST_DONE;
                            bias_en   <= 1'b0;
                            latch_clr <= 1'b0;
                            done      <= 1'b1;
                            hit_count <= acc;
                            detect    <= (int'(acc) >= THRESH);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (cont) begin
                            state   <= ST_BIAS;
                            cnt     <= BIAS_LOAD;
                            bias_en <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        bias_en   <= 1'b0;
                        led_en    <= 1'b0;
                        latch_clr <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sense_seq_ctrl.sv
// tb_sense_seq_ctrl: directed self-checking bench for the measurement sequencer
module tb_sense_seq_ctrl;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic          abort = 1'b0;
    logic [3:0]    settle_cfg = 4'd0;
    logic          comp_drv = 1'b0;
    logic          comp_rnd = 1'b0;
    logic          rnd_mode = 1'b0;
    logic          comp_raw;
    logic          bias_en, led_en, latch_clr, busy, done, detect;
    logic [CW-1:0] hit_count;
    int            vectors = 0;
    int            errors = 0;

    assign comp_raw = rnd_mode ? comp_rnd : comp_drv;

    always #5 clk = ~clk;

    sense_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .abort      (abort),
        .settle_cfg (settle_cfg),
        .comp_raw   (comp_raw),
        .bias_en    (bias_en),
        .led_en     (led_en),
        .latch_clr  (latch_clr),
        .busy       (busy),
        .done       (done),
        .hit_count  (hit_count),
        .detect     (detect)
    );

    // Comparator toggling at random phases, never on the rising clock edge
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (rnd_mode) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                d = int'($urandom_range(1, 8));
                if (d >= 5) d++;
                #(d) comp_rnd = ~comp_rnd;
            end
        end
    end

    // Raise start so that the next rising edge (edge 0) samples it
    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bias_en, led_en, latch_clr, busy, done, detect, hit_count} !== 11'd0) begin
            errors++;
            $display("FAIL reset_async: outputs=%b expected all zero",
                     {bias_en, led_en, latch_clr, busy, done, detect, hit_count});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bias_en, led_en, latch_clr, busy, done, detect, hit_count} !== 11'd0) begin
            errors++;
            $display("FAIL reset_idle: outputs=%b expected all zero",
                     {bias_en, led_en, latch_clr, busy, done, detect, hit_count});
        end
    endtask

    // One measurement; comp_raw high for edges lo..hi; optional settle_cfg change at edge chg_at
    task automatic run_meas(input logic [3:0] cfg, input int lo, input int hi,
                            input int chg_at, input logic [3:0] new_cfg,
                            input int exp_hits, input logic exp_det, input string name);
        int s, t;
        logic [4:0] exp_o, got;
        s = (int'(cfg) + 1) * 4;
        t = 8 + s + 16 + 2;
        settle_cfg = cfg;
        launch();
        for (int n = 1; n <= t + 2; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == chg_at) settle_cfg = new_cfg;
            comp_drv = (n >= lo && n <= hi);
            exp_o = {n <= t, n >= 9 && n <= 8 + s + 16, n >= t - 1 && n <= t, n <= t + 1, n == t + 1};
            got = {bias_en, led_en, latch_clr, busy, done};
            vectors++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL %s edge %0d: {bias,led,clr,busy,done}=%b expected %b", name, n, got, exp_o);
            end
            if (n == t + 1) begin
                vectors++;
                if ({detect, hit_count} !== {exp_det, CW'(exp_hits)}) begin
                    errors++;
                    $display("FAIL %s result: detect=%b hit_count=%0d expected detect=%b hit_count=%0d",
                             name, detect, hit_count, exp_det, exp_hits);
                end
            end
            @(posedge clk);
        end
        comp_drv = 1'b0;
        settle_cfg = 4'd0;
    endtask

    task automatic test_single();
        run_meas(4'd0, 1, 999, 0, 4'd0, 16, 1'b1, "single_all_high");
    endtask

    task automatic test_threshold();
        run_meas(4'd0, 11, 20, 0, 4'd0, 10, 1'b0, "thresh_10");
        run_meas(4'd0, 11, 22, 0, 4'd0, 12, 1'b1, "thresh_12");
        run_meas(4'd0, 27, 30, 0, 4'd0, 0, 1'b0, "window_late_edges");
        run_meas(4'd0, 9, 12, 0, 4'd0, 2, 1'b0, "window_early_edges");
    endtask

    task automatic test_settle();
        run_meas(4'd15, 1, 999, 20, 4'd0, 16, 1'b1, "settle_15_changed");
    endtask

    task automatic test_continuous();
        logic [1:0] exp_o;
        settle_cfg = 4'd0;
        comp_drv = 1'b0;
        cont = 1'b1;
        launch();
        for (int n = 1; n <= 95; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 70) cont = 1'b0;
            exp_o = {n % 31 == 0, n <= 93};
            vectors++;
            if ({done, busy} !== exp_o) begin
                errors++;
                $display("FAIL continuous edge %0d: {done,busy}=%b expected %b", n, {done, busy}, exp_o);
            end
            if (n % 31 == 0) begin
                vectors++;
                if ({detect, hit_count} !== 6'd0) begin
                    errors++;
                    $display("FAIL continuous result edge %0d: detect=%b hit_count=%0d expected 0/0",
                             n, detect, hit_count);
                end
            end
            @(posedge clk);
        end
    endtask

    // Abort during SAMPLE; the previous result (hit_count 2, detect 0) must survive
    task automatic test_abort();
        logic [4:0] exp_o, got;
        settle_cfg = 4'd0;
        launch();
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            comp_drv = 1'b1;
            if (n == 20) abort = 1'b1;
            if (n == 21) abort = 1'b0;
            exp_o = (n <= 20) ? {1'b1, n >= 9, 1'b0, 1'b1, 1'b0} : 5'b0;
            got = {bias_en, led_en, latch_clr, busy, done};
            vectors++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL abort edge %0d: {bias,led,clr,busy,done}=%b expected %b", n, got, exp_o);
            end
            if (n == 35) begin
                vectors++;
                if ({detect, hit_count} !== {1'b0, CW'(2)}) begin
                    errors++;
                    $display("FAIL abort_retain: detect=%b hit_count=%0d expected 0/2", detect, hit_count);
                end
            end
            @(posedge clk);
        end
        comp_drv = 1'b0;
    endtask

    task automatic test_async_comp();
        int ref_cnt, diff;
        ref_cnt = 0;
        settle_cfg = 4'd0;
        rnd_mode = 1'b1;
        launch();
        for (int n = 1; n <= 30; n++) begin
            if (n == 1) begin
                @(negedge clk);
                start = 1'b0;
            end
            @(posedge clk);
            if (n >= 11 && n <= 26) ref_cnt += int'(comp_raw);
        end
        @(negedge clk);
        diff = int'(hit_count) - ref_cnt;
        vectors++;
        if (done !== 1'b1 || $isunknown({hit_count, detect}) || diff > 2 || diff < -2) begin
            errors++;
            $display("FAIL async_comp: done=%b hit_count=%0d detect=%b expected done=1 hit_count=%0d+-2",
                     done, hit_count, detect, ref_cnt);
        end
        rnd_mode = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_settle();
        settle_cfg = 4'd3;
        launch();
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        vectors++;
        if ({bias_en, led_en, busy} !== 3'b111) begin
            errors++;
            $display("FAIL settle_active: {bias,led,busy}=%b expected 111", {bias_en, led_en, busy});
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bias_en, led_en, latch_clr, busy, done, detect, hit_count} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_settle: outputs=%b expected all zero",
                     {bias_en, led_en, latch_clr, busy, done, detect, hit_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        settle_cfg = 4'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bias_en, led_en, latch_clr, busy, done} !== 5'd0) begin
            errors++;
            $display("FAIL reset_release_idle: {bias,led,clr,busy,done}=%b expected 00000",
                     {bias_en, led_en, latch_clr, busy, done});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_threshold();
        test_abort();
        test_settle();
        test_async_comp();
        test_reset_mid_settle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
